// File: rtl/mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and pointer wrap helper.
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    function automatic int next_idx(input int id, input int n);
        return (id + 1) % n;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module mul_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one multi-cycle multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int C_WIDTH        = 32,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       ctl_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*C_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*C_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]         req_signed,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [C_WIDTH-1:0]         rsp_y,
    output logic                       rsp_err,
    output logic [C_WIDTH-1:0]         mul_a,
    output logic [C_WIDTH-1:0]         mul_b,
    output logic                       mul_signed,
    output logic                       mul_trigger,
    input  logic                       mul_ready,
    input  logic                       mul_done,
    input  logic [C_WIDTH-1:0]         mul_y,
    output logic                       mul_abort
);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               first_q, first_d;
    logic [C_WIDTH-1:0] mul_a_q, mul_a_d;
    logic [C_WIDTH-1:0] mul_b_q, mul_b_d;
    logic               mul_signed_q, mul_signed_d;
    logic               mul_trigger_q, mul_trigger_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [C_WIDTH-1:0] rsp_y_q, rsp_y_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
`endif

    mul_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // Only offer a grant when the multiplier can actually take the op.
    assign req_ready = (state_q == ST_IDLE && mul_ready && !reset) ? grant : '0;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        first_d       = first_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_signed_d  = mul_signed_q;
        mul_trigger_d = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_y_d       = rsp_y_q;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        abort_d       = 1'b0;
        err_d         = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld && mul_ready) begin
                    mul_a_d       = req_a[int'(grant_id)*C_WIDTH +: C_WIDTH];
                    mul_b_d       = req_b[int'(grant_id)*C_WIDTH +: C_WIDTH];
                    mul_signed_d  = req_signed[grant_id];
                    id_d          = grant_id;
                    mul_trigger_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                first_d = 1'b1;
                state_d = ST_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // done may still show the previous result right after the trigger
                first_d = 1'b0;
                if (!first_q && mul_done) begin
                    rsp_y_d     = mul_y;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_d     = 1'b1;
                    err_d       = 1'b1;
                    rsp_y_d     = '0;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ID_W'(next_idx(int'(id_q), NUM_REQ));
                    state_d     = ST_IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            id_q          <= '0;
            first_q       <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_signed_q  <= 1'b0;
            mul_trigger_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_y_q       <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            abort_q       <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            first_q       <= first_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_signed_q  <= mul_signed_d;
            mul_trigger_q <= mul_trigger_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_y_q       <= rsp_y_d;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            abort_q       <= abort_d;
            err_q         <= err_d;
`endif
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_signed  = mul_signed_q;
    assign mul_trigger = mul_trigger_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_y       = rsp_y_q;
`ifdef MUL_ARB_TIMEOUT_EN
    assign mul_abort   = abort_q;
    assign rsp_err     = err_q;
`else
    assign mul_abort   = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural fixed-point (Q.8) multiplier and a result scoreboard.
module tb_mul_arbiter;

    localparam int C_WIDTH = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 4;

    logic                       ctl_clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*C_WIDTH-1:0] req_a;
    logic [NUM_REQ*C_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         req_signed;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [C_WIDTH-1:0]         rsp_y;
    logic                       rsp_err;
    logic [C_WIDTH-1:0]         mul_a;
    logic [C_WIDTH-1:0]         mul_b;
    logic                       mul_signed;
    logic                       mul_trigger;
    logic                       mul_ready;
    logic                       mul_done;
    logic [C_WIDTH-1:0]         mul_y;
    logic                       mul_abort;

    mul_arbiter #(
        .C_WIDTH(C_WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(64)
    ) dut (
        .ctl_clk(ctl_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_err(rsp_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_trigger(mul_trigger),
        .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y), .mul_abort(mul_abort)
    );

    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = {{32{s & a[31]}}, a};
        sb = {{32{s & b[31]}}, b};
        p  = sa * sb;
        return p[39:8];
    endfunction

    // Behavioural multiplier: busy for MUL_LAT cycles after trigger; 'stuck' never finishes.
    logic        stuck;
    logic        m_busy, m_done;
    logic [2:0]  m_cnt;
    logic [31:0] m_y, m_a, m_b;
    logic        m_s;
    always @(posedge ctl_clk) begin
        if (reset || mul_abort) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_y <= '0;
        end else if (mul_trigger) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_cnt <= 3'(MUL_LAT);
            m_a <= mul_a; m_b <= mul_b; m_s <= mul_signed;
        end else if (m_busy) begin
            if (m_cnt == 3'd1) begin
                if (!stuck) begin
                    m_done <= 1'b1; m_busy <= 1'b0; m_y <= fx_mul(m_a, m_b, m_s);
                end
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end
    end
    assign mul_ready = !m_busy;
    assign mul_done  = m_done;
    assign mul_y     = m_y;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     y;
        logic            err;
    } exp_t;

    exp_t             exp_q[$];
    int               grant_log[$];
    logic             exp_timeout;
    logic [NUM_REQ-1:0] prev_ready;

    always @(negedge ctl_clk) begin
        if (reset) begin
            exp_q.delete();
            prev_ready = '0;
        end else begin
            if (req_ready != '0) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                chk("ready_1cyc", 64'(prev_ready), 64'd0);
            end
            prev_ready = req_ready;
            if (|(req_valid & req_ready)) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) begin
                        exp_t e;
                        e.id  = ID_W'(i);
                        e.y   = exp_timeout ? 32'h0 :
                                fx_mul(req_a[i*C_WIDTH +: C_WIDTH], req_b[i*C_WIDTH +: C_WIDTH], req_signed[i]);
                        e.err = exp_timeout;
                        exp_q.push_back(e);
                        grant_log.push_back(i);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(rsp_id), 64'(e.id));
                    chk("sb_y", 64'(rsp_y), 64'(e.y));
                    chk("sb_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[id*C_WIDTH +: C_WIDTH] = a;
        req_b[id*C_WIDTH +: C_WIDTH] = b;
        req_signed[id] = s;
        req_valid[id]  = 1'b1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        do begin @(negedge ctl_clk); n++; end while (!rsp_valid && n < 60);
        chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic wait_trig(input string tag);
        int n = 0;
        do begin @(negedge ctl_clk); n++; end while (!mul_trigger && n < 60);
        chk({tag, "_trig_seen"}, 64'(mul_trigger), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_y"}, 64'(rsp_y), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, "_mul_signed"}, 64'(mul_signed), 64'd0);
        chk({tag, "_mul_trigger"}, 64'(mul_trigger), 64'd0);
        chk({tag, "_mul_abort"}, 64'(mul_abort), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_signed = '0;
        rsp_ready = 1'b0; stuck = 1'b0; exp_timeout = 1'b0; prev_ready = '0;
        repeat (2) @(posedge ctl_clk);
        @(negedge ctl_clk);
        check_zero("rst");
        @(posedge ctl_clk); #1 reset = 1'b0; rsp_ready = 1'b1;

        // 1: single unsigned request from id 0
        drive(0, 32'h0000_0200, 32'h0000_0300, 1'b0);
        @(negedge ctl_clk);
        chk("t1_ready", 64'(req_ready), 64'h1);
        @(posedge ctl_clk); #1 req_valid = '0;
        wait_rsp("t1");
        chk("t1_id", 64'(rsp_id), 64'd0);
        chk("t1_y", 64'(rsp_y), 64'h0000_0600);
        chk("t1_err", 64'(rsp_err), 64'd0);
        @(negedge ctl_clk);
        chk("t1_drop", 64'(rsp_valid), 64'd0);

        // 2: signed request from id 2
        @(posedge ctl_clk); #1 drive(2, 32'hFFFF_FE00, 32'h0000_0300, 1'b1);
        @(posedge ctl_clk); #1 req_valid = '0;
        wait_rsp("t2");
        chk("t2_id", 64'(rsp_id), 64'd2);
        chk("t2_y", 64'(rsp_y), 64'hFFFF_FA00);

        // 4: response back-pressure holds everything
        @(posedge ctl_clk); #1 rsp_ready = 1'b0; drive(1, 32'h0000_0400, 32'h0000_0280, 1'b0);
        @(posedge ctl_clk); #1 req_valid = '0; drive(3, 32'h0000_0100, 32'h0000_0100, 1'b0);
        wait_rsp("t4");
        for (int i = 0; i < 10; i++) begin
            @(negedge ctl_clk);
            chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t4_hold_id", 64'(rsp_id), 64'd1);
            chk("t4_hold_y", 64'(rsp_y), 64'h0000_0A00);
            chk("t4_no_ready", 64'(req_ready), 64'd0);
            chk("t4_no_trig", 64'(mul_trigger), 64'd0);
        end
        @(posedge ctl_clk); #1 rsp_ready = 1'b1;

        // 5: id 3 is granted next; reset during its WAIT drops it
        wait_trig("t5");
        chk("t5_mul_a", 64'(mul_a), 64'h0000_0100);
        @(posedge ctl_clk); #1 reset = 1'b1; req_valid = '0;
        @(posedge ctl_clk); #1 reset = 1'b0;
        @(negedge ctl_clk);
        check_zero("t5");
        repeat (20) @(negedge ctl_clk);
        chk("t5_no_stale", 64'(rsp_valid), 64'd0);

        // 3: all requesters continuously valid -> 0,1,2,3,0
        grant_log.delete();
        @(posedge ctl_clk); #1;
        for (int i = 0; i < NUM_REQ; i++) drive(i, 32'((i + 1) << 8), 32'h0000_0180, 1'b0);
        n = 0;
        while (grant_log.size() < 5 && n < 500) begin @(negedge ctl_clk); n++; end
        @(posedge ctl_clk); #1 req_valid = '0;
        chk("t3_grants", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("t3_order", 64'(grant_log[i]), 64'(i % NUM_REQ));
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin @(negedge ctl_clk); n++; end
        chk("t3_drain", 64'(exp_q.size()), 64'd0);

`ifdef MUL_ARB_TIMEOUT_EN
        // 6: multiplier never finishes -> watchdog abort and error response
        @(posedge ctl_clk); #1 stuck = 1'b1; exp_timeout = 1'b1;
        drive(2, 32'h0000_0200, 32'h0000_0200, 1'b0);
        @(posedge ctl_clk); #1 req_valid = '0;
        wait_trig("t6");
        n = 0;
        do begin @(negedge ctl_clk); n++; end while (!mul_abort && n < 200);
        chk("t6_abort_cycle", 64'(n), 64'd65);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t6_err", 64'(rsp_err), 64'd1);
        chk("t6_y", 64'(rsp_y), 64'd0);
        @(negedge ctl_clk);
        chk("t6_abort_pulse", 64'(mul_abort), 64'd0);
        @(posedge ctl_clk); #1 stuck = 1'b0; exp_timeout = 1'b0;
`else
        chk("no_abort", 64'(mul_abort), 64'd0);
`endif

        repeat (5) @(negedge ctl_clk);
        chk("final_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
